// File: rtl/load_store_unit.sv
// load_store_unit: one outstanding load or store at a time, bridging the
// pipeline to a simple REQ/ACK memory bus.
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_rd, mem_we    load / store request from the pipeline
//   funct3            access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, wdata       byte address, store data
//   DRAM_i            registered, formatted load result
//   stall             pipeline hold while an access is in flight
//   mem_err           one-cycle pulse: misaligned/illegal access or bus timeout
//   bus_*             registered bus request, word-aligned, with byte enables
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] DRAM_i,
    output logic        stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_f3;     // access type of the op in flight, for load formatting
    logic [1:0]  op_off;    // byte offset of the op in flight

    // Request decode
    logic        one_op, fn_ok, aligned, accept, bad;
    logic [3:0]  be_nxt;
    logic [31:0] wd_nxt;

    always_comb begin
        fn_ok   = 1'b0;
        aligned = 1'b0;
        unique case (funct3)
            3'b000:         begin fn_ok = 1'b1;   aligned = 1'b1;              end
            3'b001:         begin fn_ok = 1'b1;   aligned = ~addr[0];          end
            3'b010:         begin fn_ok = 1'b1;   aligned = (addr[1:0] == 2'b00); end
            3'b100:         begin fn_ok = mem_rd; aligned = 1'b1;              end
            3'b101:         begin fn_ok = mem_rd; aligned = ~addr[0];          end
            default:        begin fn_ok = 1'b0;   aligned = 1'b0;              end
        endcase
        one_op = mem_rd ^ mem_we;
        accept = one_op & fn_ok & aligned;
        bad    = (mem_rd & mem_we) | (one_op & ~(fn_ok & aligned));

        unique case (funct3[1:0])
            2'b00:   begin be_nxt = 4'b0001 << addr[1:0];            wd_nxt = {4{wdata[7:0]}};  end
            2'b01:   begin be_nxt = addr[1] ? 4'b1100 : 4'b0011;     wd_nxt = {2{wdata[15:0]}}; end
            default: begin be_nxt = 4'b1111;                         wd_nxt = wdata;            end
        endcase
    end

    // Gated with rst_n so the pipeline is never held while in reset.
    assign stall = rst_n & (((state == IDLE) & accept) | (state == REQ));

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {off, 3'b000});
        h = off[1] ? d[31:16] : d[15:0];
        unique case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_f3     <= '0;
            op_off    <= '0;
            DRAM_i    <= '0;
            mem_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else begin
            mem_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        wait_cnt  <= '0;
                        op_f3     <= funct3;
                        op_off    <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_nxt;
                        bus_wdata <= wd_nxt;
                    end else if (bad) begin
                        mem_err <= 1'b1;
                    end
                end
                REQ: begin
                    // Ack wins over timeout on the last allowed cycle.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) DRAM_i <= fmt_load(op_f3, op_off, bus_rdata);
                    end else if (wait_cnt == 8'(TIMEOUT)) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                        if (!bus_we) DRAM_i <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd = 1'b0, mem_we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] DRAM_i;
    logic        stall, mem_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int n_chk = 0, n_pass = 0;

    // Per-op observations filled in by run_op
    int          n_stall, n_req;
    logic        err_seen, done_stall;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    load_store_unit #(.TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .DRAM_i(DRAM_i), .stall(stall), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present one op for a single cycle, ack in REQ cycle ack_n (0 = never),
    // and follow it through to IDLE.
    task automatic run_op(input logic rd, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_n);
        @(negedge clk);
        mem_rd = rd; mem_we = we; funct3 = f3; addr = a; wdata = wd; bus_rdata = rdat;
        #1 n_stall = int'(stall);
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_we = 1'b0;
        n_req = 0;
        while (bus_req && n_req < 400) begin
            n_req++;
            if (n_req == 1) begin
                cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
            end
            bus_ack = (n_req == ack_n);
            #1 n_stall += int'(stall);
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        if (n_req >= 400) chk("bus_req_bound", 32'(n_req), 32'd0);
        err_seen   = mem_err;
        done_stall = stall;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset: outputs cleared and stall low even with a request present
        mem_rd = 1'b1; funct3 = 3'b010;
        #3;
        chk("rst_stall",   32'(stall),   32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_dram",    DRAM_i,       32'd0);
        chk("rst_err",     32'(mem_err), 32'd0);
        chk("rst_be",      32'(bus_be),  32'd0);
        chk("rst_addr",    bus_addr,     32'd0);
        mem_rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // LB sign-extend, ack in first REQ cycle
        run_op(1, 0, 3'b000, 32'h0000_1003, 0, 32'h80FF_1234, 1);
        chk("lb_data",  DRAM_i,            32'hFFFF_FF80);
        chk("lb_stall", 32'(n_stall),      32'd2);
        chk("lb_addr",  cap_addr,          32'h0000_1000);
        chk("lb_err",   32'(err_seen),     32'd0);
        chk("lb_done_stall", 32'(done_stall), 32'd0);

        // LHU zero-extend upper half, ack in second REQ cycle
        run_op(1, 0, 3'b101, 32'h0000_1002, 0, 32'h8001_FFFF, 2);
        chk("lhu_data",  DRAM_i,       32'h0000_8001);
        chk("lhu_addr",  cap_addr,     32'h0000_1000);
        chk("lhu_stall", 32'(n_stall), 32'd3);

        // SH upper half: DRAM_i keeps the LHU result
        run_op(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'hDEAD_BEEF, 1);
        chk("sh_be",    32'(cap_be),   32'hC);
        chk("sh_wdata", cap_wdata,     32'hABCD_ABCD);
        chk("sh_we",    32'(cap_we),   32'd1);
        chk("sh_dram",  DRAM_i,        32'h0000_8001);

        // SB byte 1 and SW
        run_op(0, 1, 3'b000, 32'h0000_2001, 32'h1234_565A, 0, 1);
        chk("sb_be",    32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata,   32'h5A5A_5A5A);
        run_op(0, 1, 3'b010, 32'h0000_2000, 32'h1234_5678, 0, 1);
        chk("sw_be",    32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wdata,   32'h1234_5678);

        // LH sign-extend upper half, LBU byte 1
        run_op(1, 0, 3'b001, 32'h0000_1002, 0, 32'h8001_FFFF, 1);
        chk("lh_data", DRAM_i, 32'hFFFF_8001);
        run_op(1, 0, 3'b100, 32'h0000_1001, 0, 32'h80FF_1234, 1);
        chk("lbu_data", DRAM_i, 32'h0000_0012);

        // Misaligned LW: error pulse, no bus access, no stall
        run_op(1, 0, 3'b010, 32'h0000_1002, 0, 32'hFFFF_FFFF, 1);
        chk("mis_err",   32'(err_seen), 32'd1);
        chk("mis_req",   32'(n_req),    32'd0);
        chk("mis_stall", 32'(n_stall),  32'd0);
        chk("mis_pulse", 32'(mem_err),  32'd0);
        chk("mis_dram",  DRAM_i,        32'h0000_0012);

        // Misaligned LH, illegal funct3, store with LBU code, rd+we together
        run_op(1, 0, 3'b001, 32'h0000_1001, 0, 0, 1);
        chk("mis_lh_err", 32'(err_seen), 32'd1);
        run_op(1, 0, 3'b011, 32'h0000_1000, 0, 0, 1);
        chk("ill_f3_err", 32'(err_seen), 32'd1);
        chk("ill_f3_req", 32'(n_req),    32'd0);
        run_op(0, 1, 3'b100, 32'h0000_1000, 0, 0, 1);
        chk("ill_st_err", 32'(err_seen), 32'd1);
        run_op(1, 1, 3'b010, 32'h0000_1000, 0, 0, 1);
        chk("both_err",   32'(err_seen), 32'd1);
        chk("both_stall", 32'(n_stall),  32'd0);

        // Stray ack in IDLE is ignored
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk); bus_ack = 1'b0;
        chk("stray_dram", DRAM_i,       32'h0000_0012);
        chk("stray_req",  32'(bus_req), 32'd0);

        // Timeout: no ack for 256 REQ cycles
        run_op(1, 0, 3'b010, 32'h0000_3000, 0, 32'hCAFE_F00D, 0);
        chk("to_err",   32'(err_seen), 32'd1);
        chk("to_req",   32'(n_req),    32'd256);
        chk("to_stall", 32'(n_stall),  32'd257);
        chk("to_dram",  DRAM_i,        32'd0);
        chk("to_bus_req", 32'(bus_req), 32'd0);

        // Ack on the final allowed cycle completes normally
        run_op(1, 0, 3'b010, 32'h0000_3000, 0, 32'hCAFE_F00D, 256);
        chk("last_err",  32'(err_seen), 32'd0);
        chk("last_req",  32'(n_req),    32'd256);
        chk("last_dram", DRAM_i,        32'hCAFE_F00D);

        // Reset mid-REQ
        @(negedge clk);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000; bus_rdata = 32'h1111_2222;
        @(posedge clk); #1 mem_rd = 1'b0;
        chk("mid_req_up", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(stall),   32'd0);
        chk("mid_rst_err",   32'(mem_err), 32'd0);
        chk("mid_rst_dram",  DRAM_i,       32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(1, 0, 3'b010, 32'h0000_4000, 0, 32'h3333_4444, 1);
        chk("post_rst_stall", 32'(n_stall), 32'd2);
        chk("post_rst_dram",  DRAM_i,       32'h3333_4444);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
